// File: rtl/flash_read_arbiter_pkg.sv
// Shared definitions for the flash read arbiter: bus widths, FSM encoding
// and a small helper for turning a two-port one-hot grant into an index.
package flash_read_arbiter_pkg;

    localparam int FLASH_ADDR_W = 24;
    localparam int FLASH_BYTE_W = 8;
    localparam int NUM_PORTS    = 2;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_ARB    = 2'd1,
        ST_GAP    = 2'd2,
        ST_STREAM = 2'd3
    } fsm_state_t;

    function automatic logic grant_to_idx(input logic [NUM_PORTS-1:0] grant);
        return grant[1];
    endfunction

endpackage

// File: rtl/flash_read_arbiter_rr_arb2.sv
// Two-request round-robin arbiter: combinational one-hot grant, with a
// pointer register that moves away from whichever port was just served.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    // r_ptr = 0 favours port 0 when both ports request together
    logic r_ptr;

    always_comb begin
        o_grant = 2'b00;
        if (i_req == 2'b11) begin
            o_grant = r_ptr ? 2'b10 : 2'b01;
        end else begin
            o_grant = i_req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (i_advance && (|o_grant)) begin
            r_ptr <= o_grant[0];
        end
    end

endmodule

// File: rtl/flash_read_arbiter.sv
// Shares one QSPI XIP flash reader between an instruction-fetch port and a
// loader port: round-robin grant, do_read/addr sequencing, byte routing.
module flash_read_arbiter
    import flash_read_arbiter_pkg::*;
#(
    parameter int GAP_CYCLES = 1,
    parameter int LEN_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req0,
    input  logic                    i_req1,
    input  logic [FLASH_ADDR_W-1:0] i_addr0,
    input  logic [FLASH_ADDR_W-1:0] i_addr1,
    input  logic [LEN_W-1:0]        i_len0,
    input  logic [LEN_W-1:0]        i_len1,
    output logic                    o_ack0,
    output logic                    o_ack1,
    output logic                    o_rd_valid0,
    output logic                    o_rd_valid1,
    output logic                    o_rd_last0,
    output logic                    o_rd_last1,
    output logic [FLASH_BYTE_W-1:0] o_rd_data,
    output logic                    o_busy,
    input  logic                    i_fl_setup_done,
    output logic [FLASH_ADDR_W-1:0] o_fl_addr,
    output logic                    o_fl_do_read,
    input  logic                    i_fl_data_ready,
    input  logic [FLASH_BYTE_W-1:0] i_fl_data
);

    localparam int CNT_W = LEN_W + 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    fsm_state_t r_state;
    fsm_state_t w_state_next;

    logic [NUM_PORTS-1:0]    w_req;
    logic [NUM_PORTS-1:0]    w_grant;
    logic                    w_grant_idx;
    logic [FLASH_ADDR_W-1:0] w_addr_port [NUM_PORTS];
    logic [LEN_W-1:0]        w_len_port  [NUM_PORTS];
    logic [LEN_W-1:0]        w_len_sel;

    logic                    w_grant_take;
    logic                    w_byte_take;
    logic                    w_last_byte;
    logic                    w_fl_do_read_next;
    logic                    w_busy_next;
    logic [NUM_PORTS-1:0]    w_ack_next;
    logic [NUM_PORTS-1:0]    w_rd_valid_next;
    logic [NUM_PORTS-1:0]    w_rd_last_next;

    logic                    r_owner;
    logic [CNT_W-1:0]        r_remain;
    logic [GAP_W-1:0]        r_gap_cnt;
    logic [NUM_PORTS-1:0]    r_ack;
    logic [NUM_PORTS-1:0]    r_rd_valid;
    logic [NUM_PORTS-1:0]    r_rd_last;
    logic [FLASH_BYTE_W-1:0] r_rd_data;
    logic                    r_busy;
    logic [FLASH_ADDR_W-1:0] r_fl_addr;
    logic                    r_fl_do_read;

    assign w_req          = {i_req1, i_req0};
    assign w_addr_port[0] = i_addr0;
    assign w_addr_port[1] = i_addr1;
    assign w_len_port[0]  = i_len0;
    assign w_len_port[1]  = i_len1;
    assign w_grant_idx    = grant_to_idx(w_grant);
    assign w_len_sel      = w_len_port[w_grant_idx];

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst       (rst),
        .i_req     (w_req),
        .i_advance (w_grant_take),
        .o_grant   (w_grant)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_INIT: begin
                if (i_fl_setup_done) begin
                    w_state_next = ST_ARB;
                end
            end
            ST_ARB: begin
                if (|w_req) begin
                    w_state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (i_fl_data_ready && (r_remain == CNT_W'(1))) begin
                    w_state_next = ST_ARB;
                end
            end
            default: w_state_next = ST_INIT;
        endcase
    end

    // Output/next-value logic; do_read and busy follow the state being entered
    // so that they change in the same registered update as the state itself.
    always_comb begin
        w_grant_take      = (r_state == ST_ARB) && (|w_req);
        w_byte_take       = (r_state == ST_STREAM) && i_fl_data_ready;
        w_last_byte       = (r_remain == CNT_W'(1));
        w_fl_do_read_next = (w_state_next == ST_STREAM);
        w_busy_next       = (w_state_next == ST_GAP) || (w_state_next == ST_STREAM);
    end

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        assign w_ack_next[gi]      = w_grant_take && w_grant[gi];
        assign w_rd_valid_next[gi] = w_byte_take && (r_owner == 1'(gi));
        assign w_rd_last_next[gi]  = w_byte_take && w_last_byte && (r_owner == 1'(gi));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack        <= '0;
            r_rd_valid   <= '0;
            r_rd_last    <= '0;
            r_rd_data    <= '0;
            r_busy       <= 1'b0;
            r_fl_addr    <= '0;
            r_fl_do_read <= 1'b0;
            r_owner      <= 1'b0;
            r_remain     <= '0;
            r_gap_cnt    <= '0;
        end else begin
            r_ack        <= w_ack_next;
            r_rd_valid   <= w_rd_valid_next;
            r_rd_last    <= w_rd_last_next;
            r_busy       <= w_busy_next;
            r_fl_do_read <= w_fl_do_read_next;

            if (w_grant_take) begin
                r_owner   <= w_grant_idx;
                r_fl_addr <= w_addr_port[w_grant_idx];
                // len = 0 stands for a full 2**LEN_W byte burst
                r_remain  <= (w_len_sel == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, w_len_sel};
                r_gap_cnt <= GAP_W'(GAP_CYCLES - 1);
            end else if ((r_state == ST_GAP) && (r_gap_cnt != '0)) begin
                r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            end

            if (w_byte_take) begin
                r_rd_data <= i_fl_data;
                r_remain  <= r_remain - CNT_W'(1);
            end
        end
    end

    assign o_ack0       = r_ack[0];
    assign o_ack1       = r_ack[1];
    assign o_rd_valid0  = r_rd_valid[0];
    assign o_rd_valid1  = r_rd_valid[1];
    assign o_rd_last0   = r_rd_last[0];
    assign o_rd_last1   = r_rd_last[1];
    assign o_rd_data    = r_rd_data;
    assign o_busy       = r_busy;
    assign o_fl_addr    = r_fl_addr;
    assign o_fl_do_read = r_fl_do_read;

endmodule
